// File: rtl/riscv_multi_cycle_core_pkg.sv
// Shared types for the multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU encodings, controller bundle and decode helpers.
package riscv_multi_cycle_core_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_R     = 7'b0110011,
        OP_I     = 7'b0010011,
        OP_BEQ   = 7'b1100011,
        OP_JAL   = 7'b1101111
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_e;

    typedef enum logic [1:0] {
        WD_ALU, WD_MDR, WD_PCNEXT
    } wd_sel_e;

    typedef struct packed {
        logic    irWe;
        logic    pcNextWe;
        logic    abWe;
        logic    aluOutWe;
        logic    aluSrcImm;
        alu_op_e aluOp;
        logic    mdrWe;
        logic    rfWe;
        wd_sel_e wdSel;
        logic    pcWe;
        logic    pcSelTarget;
        logic    memReq;
        logic    memWe;
        logic    addrAlu;
        logic    retire;
        logic    halted;
    } ctrl_t;

    // I-type never subtracts; funct7[5] only selects sub for R-type.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic isR);
        case (f3)
            3'b000:  return (isR && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b010:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] imm_extend(input logic [31:0] ir);
        case (ir[6:0])
            OP_STORE: return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BEQ:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_JAL:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:  return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/riscv_multi_cycle_core_if.sv
// Shared instruction/data memory port with req/ack handshake.
interface riscv_multi_cycle_core_if #(parameter int XLEN = 32);
    logic            o_memReq;
    logic            o_memWe;
    logic [XLEN-1:0] o_memAddr;
    logic [XLEN-1:0] o_memWdata;
    logic            i_memAck;
    logic [XLEN-1:0] i_memRdata;

    modport master (output o_memReq, o_memWe, o_memAddr, o_memWdata,
                    input  i_memAck, i_memRdata);
    modport slave  (input  o_memReq, o_memWe, o_memAddr, o_memWdata,
                    output i_memAck, i_memRdata);
endinterface

// File: rtl/riscv_multi_cycle_core_controller.sv
// Central FSM: sequences each instruction and emits datapath enables/selects.
module riscv_multi_cycle_core_controller
    import riscv_multi_cycle_core_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_memAck,
    input  logic       i_eq,
    output ctrl_t      o_ctrl
);

    state_e r_state, w_next;
    logic   w_legal;

    assign w_legal = i_opcode inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL};

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (i_memAck) w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADDR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BEQ:            w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADDR:  w_next = (i_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (i_memAck) w_next = S_MEMWB;
            S_MEMWRITE: if (i_memAck) w_next = S_FETCH;
            S_EXEC_R, S_EXEC_I: w_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_ctrl       = '0;
        o_ctrl.aluOp = ALU_ADD;
        o_ctrl.wdSel = WD_ALU;
        case (r_state)
            S_FETCH: begin
                o_ctrl.memReq   = 1'b1;
                o_ctrl.irWe     = i_memAck;
                o_ctrl.pcNextWe = i_memAck;
            end
            S_DECODE: begin
                o_ctrl.abWe = 1'b1;
                o_ctrl.pcWe = !w_legal && !HALT_ON_ILLEGAL;
            end
            S_MEMADDR: begin
                o_ctrl.aluOutWe  = 1'b1;
                o_ctrl.aluSrcImm = 1'b1;
            end
            S_MEMREAD: begin
                o_ctrl.memReq  = 1'b1;
                o_ctrl.addrAlu = 1'b1;
                o_ctrl.mdrWe   = i_memAck;
            end
            S_MEMWRITE: begin
                o_ctrl.memReq  = 1'b1;
                o_ctrl.memWe   = 1'b1;
                o_ctrl.addrAlu = 1'b1;
                o_ctrl.pcWe    = i_memAck;
                o_ctrl.retire  = i_memAck;
            end
            S_MEMWB: begin
                o_ctrl.rfWe   = 1'b1;
                o_ctrl.wdSel  = WD_MDR;
                o_ctrl.pcWe   = 1'b1;
                o_ctrl.retire = 1'b1;
            end
            S_EXEC_R: begin
                o_ctrl.aluOutWe = 1'b1;
                o_ctrl.aluOp    = alu_decode(i_funct3, i_funct7b5, 1'b1);
            end
            S_EXEC_I: begin
                o_ctrl.aluOutWe  = 1'b1;
                o_ctrl.aluSrcImm = 1'b1;
                o_ctrl.aluOp     = alu_decode(i_funct3, 1'b0, 1'b0);
            end
            S_ALUWB: begin
                o_ctrl.rfWe   = 1'b1;
                o_ctrl.pcWe   = 1'b1;
                o_ctrl.retire = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.pcWe        = 1'b1;
                o_ctrl.pcSelTarget = i_eq;
                o_ctrl.retire      = 1'b1;
            end
            S_JAL: begin
                o_ctrl.rfWe        = 1'b1;
                o_ctrl.wdSel       = WD_PCNEXT;
                o_ctrl.pcWe        = 1'b1;
                o_ctrl.pcSelTarget = 1'b1;
                o_ctrl.retire      = 1'b1;
            end
            S_HALT:  o_ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_multi_cycle_core.sv
// Multi-cycle RV32I-subset core: datapath registers, register file, ALU and
// immediate extend around the central controller, one shared memory port.
module riscv_multi_cycle_core
    import riscv_multi_cycle_core_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEF,
    parameter bit              HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    riscv_multi_cycle_core_if.master   mem,
    output logic [XLEN-1:0]            o_pc,
    output logic                       o_halted,
    output logic                       o_retire
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("riscv_multi_cycle_core: XLEN must be 32");
    end

    ctrl_t           w_ctrl;
    logic [XLEN-1:0] r_pc, r_pcNext, r_ir, r_a, r_b, r_imm, r_aluOut, r_mdr;
    logic [XLEN-1:0] r_rf [32];
    logic [XLEN-1:0] w_rs1, w_rs2, w_aluB, w_aluRes, w_wd, w_addr, w_pcTarget;
    logic [4:0]      w_rd;

    riscv_multi_cycle_core_controller #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) u_ctrl (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_opcode   (r_ir[6:0]),
        .i_funct3   (r_ir[14:12]),
        .i_funct7b5 (r_ir[30]),
        .i_memAck   (mem.i_memAck),
        .i_eq       (r_a == r_b),
        .o_ctrl     (w_ctrl)
    );

    assign w_rd       = r_ir[11:7];
    assign w_rs1      = (r_ir[19:15] == 5'd0) ? '0 : r_rf[r_ir[19:15]];
    assign w_rs2      = (r_ir[24:20] == 5'd0) ? '0 : r_rf[r_ir[24:20]];
    assign w_aluB     = w_ctrl.aluSrcImm ? r_imm : r_b;
    assign w_pcTarget = r_pc + r_imm;

    always_comb begin
        w_aluRes = r_a + w_aluB;
        case (w_ctrl.aluOp)
            ALU_SUB: w_aluRes = r_a - w_aluB;
            ALU_AND: w_aluRes = r_a & w_aluB;
            ALU_OR:  w_aluRes = r_a | w_aluB;
            ALU_SLT: w_aluRes = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(w_aluB)};
            default: ;
        endcase
    end

    always_comb begin
        w_wd = r_aluOut;
        case (w_ctrl.wdSel)
            WD_MDR:    w_wd = r_mdr;
            WD_PCNEXT: w_wd = r_pcNext;
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_pc     <= RESET_PC;
            r_pcNext <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_aluOut <= '0;
            r_mdr    <= '0;
        end else begin
            if (w_ctrl.irWe)     r_ir     <= mem.i_memRdata;
            if (w_ctrl.pcNextWe) r_pcNext <= r_pc + XLEN'(4);
            if (w_ctrl.abWe) begin
                r_a   <= w_rs1;
                r_b   <= w_rs2;
                r_imm <= imm_extend(r_ir);
            end
            if (w_ctrl.aluOutWe) r_aluOut <= w_aluRes;
            if (w_ctrl.mdrWe)    r_mdr    <= mem.i_memRdata;
            if (w_ctrl.pcWe)     r_pc     <= w_ctrl.pcSelTarget ? w_pcTarget : r_pcNext;
        end
    end

    // Register file is deliberately unreset; x0 is never written.
    always_ff @(posedge i_clk) begin
        if (w_ctrl.rfWe && !i_arst && w_rd != 5'd0) r_rf[w_rd] <= w_wd;
    end

    // Reset gates the request combinationally so it drops the moment reset asserts.
    assign w_addr         = w_ctrl.addrAlu ? r_aluOut : r_pc;
    assign mem.o_memReq   = w_ctrl.memReq & ~i_arst;
    assign mem.o_memWe    = w_ctrl.memWe & ~i_arst;
    assign mem.o_memAddr  = {w_addr[XLEN-1:2], 2'b00};
    assign mem.o_memWdata = r_b;

    assign o_pc     = r_pc;
    assign o_halted = w_ctrl.halted;
    assign o_retire = w_ctrl.retire & ~i_arst;

endmodule

// File: tb/tb_riscv_multi_cycle_core.sv
// Directed bench: one program run with zero-wait and 3-wait memory, then
// illegal-opcode halt and reset during a pending fetch.
module tb_riscv_multi_cycle_core;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [31:0] pc;
    logic        halted, retire;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    riscv_multi_cycle_core_if #(.XLEN(32)) bus ();

    riscv_multi_cycle_core #(.XLEN(32), .RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1)) dut (
        .i_clk    (clk),
        .i_arst   (arst),
        .mem      (bus.master),
        .o_pc     (pc),
        .o_halted (halted),
        .o_retire (retire)
    );

    localparam logic [31:0] PROG [18] = '{
        32'h00500093, 32'h08102023, 32'h08002103, 32'h002081B3,  // addi sw lw add
        32'h40308233, 32'h001222B3, 32'h00208863, 32'h0000007F,  // sub slt beq(T)
        32'h0000007F, 32'h0000007F, 32'h00308863, 32'h0080036F,  // 0x28 beq(NT), jal
        32'h0000007F, 32'h0061F393, 32'hFFF06413, 32'hFFC22493,  // andi ori slti
        32'h00700013, 32'h0000007F                               // addi x0, illegal
    };
    localparam int          CYC0 [13] = '{4, 8, 13, 17, 21, 25, 28, 31, 34, 38, 42, 46, 50};
    localparam int          CYC3 [13] = '{7, 17, 28, 35, 42, 49, 55, 61, 67, 74, 81, 88, 95};
    localparam logic [31:0] PCS  [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                                          32'h28, 32'h2C, 32'h34, 32'h38, 32'h3C, 32'h40};
    localparam logic [31:0] REGS [10] = '{32'h0, 32'h5, 32'h5, 32'hA, 32'hFFFFFFFB, 32'h1,
                                          32'h30, 32'h2, 32'hFFFFFFFF, 32'h1};

    // Memory slave with programmable wait states
    logic [31:0] memArr [64];
    int          waitStates = 0;
    int          waitCnt;
    logic [31:0] wrAddr[$], wrData[$];

    assign bus.i_memAck   = bus.o_memReq && (waitCnt >= waitStates);
    assign bus.i_memRdata = memArr[bus.o_memAddr[7:2]];

    always @(posedge clk or posedge arst) begin
        if (arst)                                 waitCnt <= 0;
        else if (bus.o_memReq && !bus.i_memAck)   waitCnt <= waitCnt + 1;
        else                                      waitCnt <= 0;
    end

    always @(posedge clk) begin
        if (!arst && bus.o_memReq && bus.o_memWe && bus.i_memAck) begin
            memArr[bus.o_memAddr[7:2]] <= bus.o_memWdata;
            wrAddr.push_back(bus.o_memAddr);
            wrData.push_back(bus.o_memWdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Retire log and request-hold monitor, sampled on the falling edge
    int          cyc;
    int          retCyc[$];
    logic [31:0] retPc[$];
    logic        pend;
    logic [31:0] pAddr, pWdata;
    logic        pWe;

    always @(negedge clk) begin
        if (arst) begin
            cyc  <= 0;
            pend <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (retire) begin
                retCyc.push_back(cyc + 1);
                retPc.push_back(pc);
            end
            if (pend) begin
                chk("hold_req", {31'b0, bus.o_memReq}, 32'h1);
                chk("hold_addr", bus.o_memAddr, pAddr);
                chk("hold_we", {31'b0, bus.o_memWe}, {31'b0, pWe});
                if (pWe) chk("hold_wdata", bus.o_memWdata, pWdata);
            end
            pend   <= bus.o_memReq && !bus.i_memAck;
            pAddr  <= bus.o_memAddr;
            pWe    <= bus.o_memWe;
            pWdata <= bus.o_memWdata;
        end
    end

    task automatic load_prog();
        for (int i = 0; i < 64; i++) memArr[i] <= (i < 18) ? PROG[i] : 32'h0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        load_prog();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus.o_memReq}, 32'h0);
        chk("rst_we", {31'b0, bus.o_memWe}, 32'h0);
        chk("rst_retire", {31'b0, retire}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        retCyc.delete();
        retPc.delete();
        wrAddr.delete();
        wrData.delete();
        @(posedge clk);
        #1 arst = 1'b0;
    endtask

    task automatic run_prog(input int ws, input int expCyc [13]);
        waitStates = ws;
        do_reset();
        @(negedge clk);
        #1;
        chk("first_fetch_req", {31'b0, bus.o_memReq}, 32'h1);
        chk("first_fetch_addr", bus.o_memAddr, 32'h0);
        for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
        chk("halt_reached", {31'b0, halted}, 32'h1);
        chk("ret_count", retCyc.size(), 13);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("ws%0d_ret_cyc[%0d]", ws, i), retCyc[i], expCyc[i]);
            chk($sformatf("ws%0d_ret_pc[%0d]", ws, i), retPc[i], PCS[i]);
        end
        for (int r = 1; r < 10; r++)
            chk($sformatf("ws%0d_x%0d", ws, r), dut.r_rf[r], REGS[r]);
        chk("wr_count", wrAddr.size(), 1);
        chk("wr_addr", wrAddr[0], 32'h80);
        chk("wr_data", wrData[0], 32'h5);
        chk("mem_word32", memArr[32], 32'h5);
        repeat (6) @(negedge clk);
        chk("halt_stays", {31'b0, halted}, 32'h1);
        chk("halt_no_req", {31'b0, bus.o_memReq}, 32'h0);
        chk("halt_pc", pc, 32'h44);
    endtask

    initial begin
        run_prog(0, CYC0);
        run_prog(3, CYC3);

        // Reset asserted while a fetch is stalled waiting for ack
        waitStates = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("midfetch_req", {31'b0, bus.o_memReq}, 32'h1);
        #2 arst = 1'b1;
        #1;
        chk("midrst_req_drop", {31'b0, bus.o_memReq}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        chk("restart_req", {31'b0, bus.o_memReq}, 32'h1);
        chk("restart_addr", bus.o_memAddr, 32'h0);
        for (int i = 0; i < 10 && !retire; i++) @(negedge clk);
        chk("restart_retire_pc", pc, 32'h0);
        chk("restart_x1", dut.r_rf[1], 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
